// File: rtl/operand_fetch_pkg.sv
// Shared widths, register count and FSM state encoding for the operand-fetch stage.
package operand_fetch_pkg;

  localparam int N    = 72;
  localparam int A    = 6;
  localparam int OPW  = 8;
  localparam int NREG = 1 << A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    VALID = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPW-1:0] opcode;
    logic [A-1:0]   rd;
    logic           we;
  } instr_meta_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-side and execute-side handshakes of the operand-fetch stage.
interface operand_fetch_if;
  import operand_fetch_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_opcode;
  logic [A-1:0]   in_rs1;
  logic [A-1:0]   in_rs2;
  logic [A-1:0]   in_rd;
  logic           in_we;

  logic           out_valid;
  logic           out_ready;
  logic [OPW-1:0] out_opcode;
  logic [A-1:0]   out_rd;
  logic           out_we;
  logic [N-1:0]   out_op1;
  logic [N-1:0]   out_op2;

  modport slave (
    input  in_valid, in_opcode, in_rs1, in_rs2, in_rd, in_we, out_ready,
    output in_ready, out_valid, out_opcode, out_rd, out_we, out_op1, out_op2
  );

  modport master (
    output in_valid, in_opcode, in_rs1, in_rs2, in_rd, in_we, out_ready,
    input  in_ready, out_valid, out_opcode, out_rd, out_we, out_op1, out_op2
  );

endinterface

// File: rtl/operand_fetch_reg_scoreboard.sv
// One busy bit per architectural register; a set and a clear of the same
// register in one cycle leaves it busy.
module reg_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         set_en,
  input  logic [A-1:0] set_addr,
  input  logic         clr_en,
  input  logic [A-1:0] clr_addr,
  input  logic [A-1:0] look1_addr,
  input  logic [A-1:0] look2_addr,
  input  logic [A-1:0] look3_addr,
  output logic         busy1,
  output logic         busy2,
  output logic         busy3
);

  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_bit
      logic set_hit;
      logic clr_hit;
      assign set_hit = set_en && (set_addr == A'(gi));
      assign clr_hit = clr_en && (clr_addr == A'(gi));
      // Set is applied after clear so a coincident set always wins.
      assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy1 = busy_reg[look1_addr];
  assign busy2 = busy_reg[look2_addr];
  assign busy3 = busy_reg[look3_addr];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: issues register-file reads, captures the registered
// read data and hands a complete operand bundle to execute.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  operand_fetch_if.slave  bus,
  output logic [A-1:0]    reg1_address,
  output logic [A-1:0]    reg2_address,
  input  logic [N-1:0]    rf_data1,
  input  logic [N-1:0]    rf_data2,
  input  logic            wb_valid,
  input  logic [A-1:0]    wb_addr
);

  state_t      state_reg;
  state_t      state_next;
  logic [A-1:0] rs1_reg;
  logic [A-1:0] rs2_reg;
  instr_meta_t pend_reg;
  instr_meta_t out_meta_reg;
  logic [N-1:0] op1_reg;
  logic [N-1:0] op2_reg;

  logic busy_rs1;
  logic busy_rs2;
  logic busy_rd;
  logic hazard;
  logic ready;
  logic acc;

  reg_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .set_en     (acc && bus.in_we),
    .set_addr   (bus.in_rd),
    .clr_en     (wb_valid),
    .clr_addr   (wb_addr),
    .look1_addr (bus.in_rs1),
    .look2_addr (bus.in_rs2),
    .look3_addr (bus.in_rd),
    .busy1      (busy_rs1),
    .busy2      (busy_rs2),
    .busy3      (busy_rd)
  );

  // Hazard looks only at registered busy bits: a same-cycle writeback does not bypass.
  assign hazard = busy_rs1 || busy_rs2 || (bus.in_we && busy_rd);
  assign ready  = !reset && !hazard &&
                  ((state_reg == IDLE) || ((state_reg == VALID) && bus.out_ready));
  assign acc    = bus.in_valid && ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (acc) state_next = READ;
      READ:    state_next = VALID;
      VALID:   if (bus.out_ready) state_next = acc ? READ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      pend_reg     <= '0;
      out_meta_reg <= '0;
      op1_reg      <= '0;
      op2_reg      <= '0;
    end else begin
      if (acc) begin
        rs1_reg  <= bus.in_rs1;
        rs2_reg  <= bus.in_rs2;
        pend_reg <= '{opcode: bus.in_opcode, rd: bus.in_rd, we: bus.in_we};
      end
      if (state_reg == READ) begin
        op1_reg      <= rf_data1;
        op2_reg      <= rf_data2;
        out_meta_reg <= pend_reg;
      end
    end
  end

  assign reg1_address = acc ? bus.in_rs1 : rs1_reg;
  assign reg2_address = acc ? bus.in_rs2 : rs2_reg;

  assign bus.in_ready   = ready;
  assign bus.out_valid  = (state_reg == VALID);
  assign bus.out_opcode = out_meta_reg.opcode;
  assign bus.out_rd     = out_meta_reg.rd;
  assign bus.out_we     = out_meta_reg.we;
  assign bus.out_op1    = op1_reg;
  assign bus.out_op2    = op2_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: an occupancy/scoreboard model checks every
// cycle, literal expectations pin the key scenarios.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  operand_fetch_if bus ();

  logic [A-1:0] reg1_address;
  logic [A-1:0] reg2_address;
  logic [N-1:0] rf_data1 = '0;
  logic [N-1:0] rf_data2 = '0;
  logic         wb_valid = 1'b0;
  logic [A-1:0] wb_addr = '0;

  logic [N-1:0] rf_mem [NREG];

  int vectors = 0;
  int miscompares = 0;

  operand_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .reg1_address (reg1_address),
    .reg2_address (reg2_address),
    .rf_data1     (rf_data1),
    .rf_data2     (rf_data2),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr)
  );

  // Register file: read data registered one cycle after the address.
  always @(posedge clk) begin
    rf_data1 <= rf_mem[reg1_address];
    rf_data2 <= rf_mem[reg2_address];
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [OPW-1:0] opcode;
    logic [A-1:0]   rd;
    logic           we;
    logic [N-1:0]   op1;
    logic [N-1:0]   op2;
  } bundle_t;

  // Model: set of busy registers, one instruction in flight, one bundle presented.
  bit           m_init = 1'b0;
  bit           m_busy [NREG];
  bit           m_inflight;
  bit           m_has_out;
  bundle_t      m_fly;
  bundle_t      m_out;
  logic [A-1:0] m_last_rs1;
  logic [A-1:0] m_last_rs2;

  initial begin
    bit hz, exp_ready, exp_acc;
    forever begin
      @(negedge clk);
      if (reset) begin
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_inflight = 1'b0;
        m_has_out  = 1'b0;
        m_last_rs1 = '0;
        m_last_rs2 = '0;
        m_init     = 1'b1;
      end else if (m_init) begin
        hz = m_busy[bus.in_rs1] || m_busy[bus.in_rs2] || (bus.in_we && m_busy[bus.in_rd]);
        exp_ready = !m_inflight && (!m_has_out || bus.out_ready) && !hz;
        exp_acc   = bus.in_valid && exp_ready;
        check("in_ready", N'(bus.in_ready), N'(exp_ready));
        check("out_valid", N'(bus.out_valid), N'(m_has_out));
        check("reg1_address", N'(reg1_address), N'(exp_acc ? bus.in_rs1 : m_last_rs1));
        check("reg2_address", N'(reg2_address), N'(exp_acc ? bus.in_rs2 : m_last_rs2));
        if (m_has_out) begin
          check("out_opcode", N'(bus.out_opcode), N'(m_out.opcode));
          check("out_rd", N'(bus.out_rd), N'(m_out.rd));
          check("out_we", N'(bus.out_we), N'(m_out.we));
          check("out_op1", bus.out_op1, m_out.op1);
          check("out_op2", bus.out_op2, m_out.op2);
          if (bus.out_ready)
            $display("txn out opcode=%h rd=%0d we=%0b op1=%h op2=%h",
                     bus.out_opcode, bus.out_rd, bus.out_we, bus.out_op1, bus.out_op2);
        end
        if (wb_valid) m_busy[wb_addr] = 1'b0;
        if (exp_acc && bus.in_we) m_busy[bus.in_rd] = 1'b1;
        if (m_has_out && bus.out_ready) m_has_out = 1'b0;
        if (m_inflight) begin
          m_out      = m_fly;
          m_has_out  = 1'b1;
          m_inflight = 1'b0;
        end
        if (exp_acc) begin
          m_fly = '{opcode: bus.in_opcode, rd: bus.in_rd, we: bus.in_we,
                    op1: rf_mem[bus.in_rs1], op2: rf_mem[bus.in_rs2]};
          m_inflight = 1'b1;
          m_last_rs1 = bus.in_rs1;
          m_last_rs2 = bus.in_rs2;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [OPW-1:0] op, input logic [A-1:0] rs1,
                       input logic [A-1:0] rs2, input logic [A-1:0] rd, input logic we);
    bus.in_opcode = op;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_rd     = rd;
    bus.in_we     = we;
    bus.in_valid  = 1'b1;
  endtask

  // Present an instruction and hold it until accepted (bounded wait).
  task automatic issue(input logic [OPW-1:0] op, input logic [A-1:0] rs1,
                       input logic [A-1:0] rs2, input logic [A-1:0] rd, input logic we);
    bit got = 1'b0;
    drive(op, rs1, rs2, rd, we);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("accept_timeout", N'(got), N'(1'b1));
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREG; i++)
      rf_mem[i] = {8'(i), 64'hC0DE_0000_0000_0000 + 64'(i * 7919)};
    rf_mem[3] = 72'h0A_AAAA_AAAA_AAAA_AAAA;
    rf_mem[5] = 72'h05_5555_5555_5555_5555;
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_rd     = '0;
    bus.in_we     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", N'(bus.in_ready), '0);
    check("rst_out_valid", N'(bus.out_valid), '0);
    check("rst_out_op1", bus.out_op1, '0);
    check("rst_out_rd", N'(bus.out_rd), '0);
    check("rst_reg1_address", N'(reg1_address), '0);
    tick();
    reset = 1'b0;

    // Single issue: bundle appears two cycles after acceptance
    issue(8'h11, 6'd3, 6'd5, 6'd7, 1'b1);
    @(negedge clk);
    check("single_lat1_out_valid", N'(bus.out_valid), '0);
    tick();
    @(negedge clk);
    check("single_out_valid", N'(bus.out_valid), N'(1'b1));
    check("single_op1", bus.out_op1, 72'h0A_AAAA_AAAA_AAAA_AAAA);
    check("single_op2", bus.out_op2, 72'h05_5555_5555_5555_5555);
    check("single_rd", N'(bus.out_rd), N'(6'd7));
    check("single_we", N'(bus.out_we), N'(1'b1));

    // RAW stall on r7 until writeback, accepted the cycle after the clear
    tick();
    bus.out_ready = 1'b1;
    drive(8'h22, 6'd7, 6'd1, 6'd8, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("raw_stall", N'(bus.in_ready), '0);
      tick();
    end
    wb_valid = 1'b1;
    wb_addr  = 6'd7;
    @(negedge clk);
    check("raw_clear_cycle", N'(bus.in_ready), '0);
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    check("raw_after_clear", N'(bus.in_ready), N'(1'b1));
    tick();
    bus.in_valid = 1'b0;

    // Backpressure: READ cycle then 5 held VALID cycles, then back-to-back accept
    bus.out_ready = 1'b0;
    drive(8'h33, 6'd2, 6'd4, 6'd10, 1'b0);
    repeat (6) begin
      @(negedge clk);
      check("bp_in_ready", N'(bus.in_ready), '0);
      tick();
    end
    check("bp_held_rd", N'(bus.out_rd), N'(6'd8));
    check("bp_held_op1", bus.out_op1, rf_mem[7]);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("b2b_accept", N'(bus.in_ready), N'(1'b1));
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_read_gap", N'(bus.out_valid), '0);
    tick();
    @(negedge clk);
    check("b2b_out_valid", N'(bus.out_valid), N'(1'b1));
    check("b2b_out_rd", N'(bus.out_rd), N'(6'd10));
    tick();

    // WAW on r9 and set-wins with a coincident writeback to r9
    issue(8'h44, 6'd1, 6'd2, 6'd9, 1'b1);
    drive(8'h55, 6'd1, 6'd2, 6'd9, 1'b1);
    repeat (2) begin
      @(negedge clk);
      check("waw_stall", N'(bus.in_ready), '0);
      tick();
    end
    wb_valid = 1'b1;
    wb_addr  = 6'd9;
    @(negedge clk);
    check("waw_clear_cycle", N'(bus.in_ready), '0);
    tick();
    @(negedge clk);
    check("waw_accept_with_wb", N'(bus.in_ready), N'(1'b1));
    tick();
    wb_valid = 1'b0;
    drive(8'h66, 6'd9, 6'd2, 6'd11, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("set_wins_busy9", N'(bus.in_ready), '0);
      tick();
    end
    wb_valid = 1'b1;
    @(negedge clk);
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    check("r9_released", N'(bus.in_ready), N'(1'b1));
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();

    // Spurious writeback to idle r12 changes nothing; r8 stays busy
    wb_valid = 1'b1;
    wb_addr  = 6'd12;
    tick();
    wb_valid = 1'b0;
    drive(8'h77, 6'd12, 6'd12, 6'd12, 1'b1);
    @(negedge clk);
    check("spurious_wb_r12_free", N'(bus.in_ready), N'(1'b1));
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    drive(8'h88, 6'd8, 6'd0, 6'd13, 1'b0);
    @(negedge clk);
    check("r8_still_busy", N'(bus.in_ready), '0);
    tick();
    wb_valid = 1'b1;
    wb_addr  = 6'd8;
    tick();
    wb_valid = 1'b0;
    issue(8'h88, 6'd8, 6'd0, 6'd13, 1'b0);

    // Throughput: independent instructions back to back
    for (int k = 0; k < 4; k++)
      issue(8'hB0 + 8'(k), 6'(20 + k), 6'(30 + k), 6'(40 + k), 1'b0);
    repeat (3) tick();

    // Reset while in READ with r4 busy
    issue(8'h99, 6'd0, 6'd1, 6'd4, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", N'(bus.out_valid), '0);
    check("rst_mid_op1", bus.out_op1, '0);
    check("rst_mid_op2", bus.out_op2, '0);
    check("rst_mid_opcode", N'(bus.out_opcode), '0);
    check("rst_mid_rd", N'(bus.out_rd), '0);
    check("rst_mid_we", N'(bus.out_we), '0);
    check("rst_mid_reg1_address", N'(reg1_address), '0);
    tick();
    drive(8'hAA, 6'd4, 6'd4, 6'd4, 1'b1);
    @(negedge clk);
    check("rst_mid_r4_cleared", N'(bus.in_ready), N'(1'b1));
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage that sits directly upstream of the 72-bit register file and downstream of decode. It accepts decoded instructions over a valid/ready handshake and drives the register file's two read addresses. It captures the registered read data one cycle later and presents a complete operand bundle to execute over a second valid/ready handshake. A 64-entry busy scoreboard blocks issue on read-after-write and write-after-write hazards until writeback clears the destination.

## Interface
- N, 72, operand data width (matches register file)
- A, 6, register address width (64 architectural registers)
- OPW, 8, opcode width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_opcode  in  OPW  opcode
- in_rs1, in_rs2  in  A  source register addresses
- in_rd  in  A  destination register address
- in_we  in  1  instruction writes in_rd
- reg1_address, reg2_address  out  A  read addresses to the register file
- rf_data1, rf_data2  in  N  register-file read data; valid the cycle after the addresses are sampled
- wb_valid  in  1  writeback retires a write
- wb_addr  in  A  register being written back; clears its busy bit
- out_valid  out  1  operand bundle valid
- out_ready  in  1  execute accepts the bundle
- out_opcode, out_rd, out_we  out  OPW/A/1  passed-through fields
- out_op1, out_op2  out  N  operand values

## Operation
- FSM states: IDLE, READ, VALID.
- Accept condition: acc = in_valid & in_ready.
- in_ready = (state==IDLE | (state==VALID & out_ready)) & ~hazard.
- hazard = busy[in_rs1] | busy[in_rs2] | (in_we & busy[in_rd]).
- Address mux:
  - when acc, reg1/2_address = in_rs1/in_rs2 (combinational);
  - otherwise they hold the last accepted rs1/rs2 (registered copy).
- IDLE: acc → READ; latch opcode/rd/we/rs1/rs2.
- READ, always exactly one cycle:
  - capture rf_data1/rf_data2 into out_op1/out_op2;
  - → VALID.
- VALID: out_valid=1; bundle held stable while out_ready=0.
  - out_ready & acc → READ (back-to-back);
  - out_ready & ~acc → IDLE.
- Scoreboard:
  - on acc with in_we, set busy[in_rd];
  - on wb_valid, clear busy[wb_addr];
  - same address set and cleared in one cycle: set wins;
  - wb_valid to a non-busy address: no effect.
- Clearing does not bypass hazard combinationally; a blocked instruction is accepted the cycle after the clear.
- Register 0 is an ordinary register: it is scoreboarded like any other.

## Timing
- Reset values:
  - state IDLE; out_valid 0; in_ready 0 during reset;
  - out_opcode, out_rd, out_we, out_op1, out_op2 all 0;
  - reg1/2_address 0; busy all 0.
- Reset mid-operation discards any in-flight bundle and clears every busy bit.
- Latency: acceptance in cycle t → out_valid in cycle t+2.
- Throughput:
  - one instruction per 2 cycles with out_ready held high;
  - hazard or backpressure stalls in place, with no loss or duplication.
- Outputs are registered and change only on rising clk after an out handshake or a READ capture.

## Structure
- Shared package operand_fetch_pkg: N, A, OPW constants; FSM state enum (IDLE, READ, VALID).
- Sub-module reg_scoreboard:
  - 2^A busy bits;
  - ports: set_en, set_addr, clr_en, clr_addr, three lookup addresses, three busy outputs;
  - implements the set-wins rule.
- Top level holds the FSM, the address mux and the capture registers.

## Test plan
- Single issue: rs1=3, rs2=5, rd=7, we=1, rf returns 0x0AA…/0x055… → out_valid at t+2 with out_op1/out_op2 equal to those values, out_rd=7, busy[7]=1.
- RAW stall: after the previous issue, in_rs1=7 → in_ready=0 until wb_valid with wb_addr=7; accepted the cycle after the clear.
- Backpressure: out_ready=0 for 5 cycles in VALID → bundle unchanged, in_ready=0; out_ready=1 with in_valid=1 → back-to-back accept, next bundle at +2.
- WAW and set-wins: wb_valid to rd=9 in the same cycle as a new acc with in_rd=9, in_we=1 → busy[9]=1 afterwards.
- Spurious writeback: wb_valid with wb_addr=12 while busy[12]=0 → no state change.
- Reset mid-op: assert reset while in READ with busy[4]=1 → next cycle IDLE, out_valid=0, all outputs 0, busy[4]=0.
